// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO, with per-frame latched parity/stop/prescale settings
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_data_valid,
  input  logic [DATA_W-1:0]             i_data,
  output logic                          o_ready,
  input  logic [PRESCALE_W-1:0]         i_prescale,
  input  logic                          i_en_par,
  input  logic                          i_par_type,
  input  logic                          i_two_stop,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] sh;
  logic [PRESCALE_W-1:0] ps_l, cnt, ps_in;
  logic [BW-1:0] bit_cnt;
  logic par_l, en_par_l, two_l;
  logic wr, tick, stop_done, pop;
  assign o_ready   = o_count != CW'(FIFO_DEPTH);
  assign wr        = i_data_valid && o_ready;
  assign tick      = cnt == '0;
  assign stop_done = state == STOP && tick && !(two_l && bit_cnt == '0);
  assign pop       = o_count != '0 && (state == IDLE || stop_done);
  assign ps_in     = i_prescale == '0 ? ONE : i_prescale;
  assign o_busy    = state != IDLE || o_count != '0;
  // storage needs no reset; only the pointers define validity
  always_ff @(posedge i_clk)
    if (wr) mem[wr_ptr] <= i_data;
  // pointers wrap naturally at the power-of-two depth; simultaneous push/pop keeps the count
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(wr);
      rd_ptr  <= rd_ptr + AW'(pop);
      o_count <= o_count + CW'(wr) - CW'(pop);
    end
  // frame sequencer: a pop starts a frame and latches its config; cnt times each bit period
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state    <= IDLE;
      o_tx     <= 1'b1;
      sh       <= '0;
      ps_l     <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      par_l    <= 1'b0;
      en_par_l <= 1'b0;
      two_l    <= 1'b0;
    end else if (pop) begin
      state    <= START;
      o_tx     <= 1'b0;
      sh       <= mem[rd_ptr];
      par_l    <= ^mem[rd_ptr] ^ i_par_type;
      ps_l     <= ps_in;
      cnt      <= ps_in - ONE;
      bit_cnt  <= '0;
      en_par_l <= i_en_par;
      two_l    <= i_two_stop;
    end else if (state == IDLE) begin
      o_tx <= 1'b1;
      cnt  <= '0;
    end else if (!tick) begin
      cnt <= cnt - ONE;
    end else begin
      cnt <= ps_l - ONE;
      case (state)
        START: begin
          state <= DATA;
          o_tx  <= sh[0];
        end
        DATA:
          if (bit_cnt == BW'(DATA_W - 1)) begin
            state   <= en_par_l ? PARITY : STOP;
            o_tx    <= en_par_l ? par_l : 1'b1;
            bit_cnt <= '0;
          end else begin
            sh      <= sh >> 1;
            o_tx    <= sh[1];
            bit_cnt <= bit_cnt + BW'(1);
          end
        PARITY: begin
          state <= STOP;
          o_tx  <= 1'b1;
        end
        STOP:
          if (stop_done) state <= IDLE;
          else bit_cnt <= bit_cnt + BW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO back-pressure, reset abort and config latching
module tb_uart_tx_fifo;
  logic i_clk = 1'b0, i_rst = 1'b0, i_data_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic o_ready, o_tx, o_busy;
  logic [15:0] i_prescale = 16'd4;
  logic i_en_par = 1'b0, i_par_type = 1'b0, i_two_stop = 1'b0;
  logic [2:0] o_count;
  int checks = 0, failures = 0;
  logic [7:0] words [6];

  uart_tx_fifo dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data_valid(i_data_valid), .i_data(i_data),
    .o_ready(o_ready), .i_prescale(i_prescale), .i_en_par(i_en_par),
    .i_par_type(i_par_type), .i_two_stop(i_two_stop), .o_tx(o_tx),
    .o_busy(o_busy), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bits[0] is the start bit; each bit is checked on every one of its p clocks, skipping already-elapsed clocks
  task automatic check_bits(input logic [15:0] bits, input int n, input int p, input int skip, input string tag);
    for (int c = skip; c < n * p; c++) begin
      @(negedge i_clk);
      chk({31'b0, o_tx}, {31'b0, bits[c / p]}, tag);
    end
  endtask

  task automatic write_one(input logic [7:0] d);
    @(negedge i_clk);
    i_data_valid = 1'b1;
    i_data = d;
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  initial begin
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    #2 i_rst = 1'b1;
    #2;
    chk(o_tx, 1, "rst_tx");
    chk(o_count, 0, "rst_count");
    chk(o_ready, 1, "rst_ready");
    chk(o_busy, 0, "rst_busy");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    write_one(8'h55);
    chk(o_tx, 1, "t034_pre_tx");
    chk(o_count, 1, "t034_count");
    chk(o_busy, 1, "t034_busy");
    check_bits({6'b0, 1'b1, 8'h55, 1'b0}, 10, 4, 0, "t034_tx");
    chk(o_busy, 1, "t034_busy_stop");
    @(negedge i_clk);
    chk(o_busy, 0, "t034_busy_end");
    chk(o_tx, 1, "t034_idle_tx");

    i_prescale = 16'd2; i_en_par = 1'b1; i_par_type = 1'b1;
    write_one(8'hA3);
    check_bits({5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11, 2, 0, "t035_tx");
    @(negedge i_clk);
    chk(o_busy, 0, "t035_busy_end");

    i_prescale = 16'd0; i_en_par = 1'b0; i_par_type = 1'b0; i_two_stop = 1'b1;
    write_one(8'hFF);
    check_bits({5'b0, 2'b11, 8'hFF, 1'b0}, 11, 1, 0, "t037_tx");
    @(negedge i_clk);
    chk(o_busy, 0, "t037_busy_end");

    i_prescale = 16'd16; i_two_stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      chk(o_ready, (k < 5) ? 1 : 0, "t036_ready");
      i_data_valid = 1'b1;
      i_data = words[k];
    end
    @(negedge i_clk);
    i_data_valid = 1'b0;
    chk(o_count, 4, "t036_count");
    chk(o_ready, 0, "t036_full");
    check_bits({6'b0, 1'b1, words[0], 1'b0}, 10, 16, 5, "t036_w0");
    for (int k = 1; k < 5; k++)
      check_bits({6'b0, 1'b1, words[k], 1'b0}, 10, 16, 0, "t036_wk");
    @(negedge i_clk);
    chk(o_busy, 0, "t036_busy_end");
    chk(o_count, 0, "t036_count_end");

    i_prescale = 16'd4; i_en_par = 1'b1; i_par_type = 1'b0;
    @(negedge i_clk);
    i_data_valid = 1'b1; i_data = 8'h07;
    @(negedge i_clk);
    i_data = 8'h03;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    i_par_type = 1'b1; i_prescale = 16'd2;
    chk(o_tx, 0, "t039_start");
    check_bits({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, 1, "t039_f0");
    check_bits({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 2, 0, "t039_f1");
    @(negedge i_clk);
    chk(o_busy, 0, "t039_busy_end");

    i_prescale = 16'd4; i_en_par = 1'b0; i_par_type = 1'b0;
    @(negedge i_clk);
    i_data_valid = 1'b1; i_data = 8'h0A;
    @(negedge i_clk);
    i_data = 8'h0B;
    @(negedge i_clk);
    i_data = 8'h0C;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    chk(o_count, 2, "t038_queued");
    repeat (12) @(negedge i_clk);
    chk(o_tx, 0, "t038_bit2");
    i_rst = 1'b1;
    #1;
    chk(o_tx, 1, "t038_rst_tx");
    chk(o_count, 0, "t038_rst_count");
    chk(o_busy, 0, "t038_rst_busy");
    chk(o_ready, 1, "t038_rst_ready");
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      chk({o_tx, o_busy}, 2'b10, "t038_quiet");
    end
    write_one(8'h5A);
    chk(o_tx, 1, "t038_new_pre");
    check_bits({6'b0, 1'b1, 8'h5A, 1'b0}, 10, 4, 0, "t038_new");
    @(negedge i_clk);
    chk(o_busy, 0, "t038_busy_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
